sram_responder: RTL and testbench

- Pin-side responder for the SRAM controller interface: the device end of the ce/we/oe/adv/cre/lb/ub/sram_data bus.
- Synthesisable 2^ADDR_W x DATA_W array with byte-lane masking, a configuration register reached through cre, and a programmable read latency signalled on wait_out.
- Stands in for the external cellular RAM in simulation and FPGA loopback tests.
- Runs on the system clock; the controller's sram_clk is not used.

---
 rtl/sram_responder.sv | 147 ++++++++++++++
 tb/tb_sram_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Device-side cellular RAM stand-in: byte-lane masked array, cre-reached latency
// register and wait_out read latency. SRAM_RESP_BURST_EN enables addr auto-increment.
module sram_responder #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    input  logic              ce,
    input  logic              we,
    input  logic              oe,
    input  logic              adv,
    input  logic              cre,
    input  logic              lb,
    input  logic              ub,
    output logic              wait_out,
    output logic              wr_strobe,
    output logic              rd_strobe,
    output logic [1:0]        state
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned HALF  = DATA_W / 2;

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RD_LAT = 2'd2, RD_DRV = 2'd3} st_t;

    st_t               st_q, st_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic              is_cfg;
    logic [1:0]        cfg_lat;
    logic [1:0]        lat_cnt;
    logic [DATA_W-1:0] rd_q;
    logic              latch, do_wr, ld_rd, lat_start, lat_inc;
    logic              drv_en;
    logic [DATA_W-1:0] cfg_word;
`ifdef SRAM_RESP_BURST_EN
    logic              rd_step;
    logic [ADDR_W-1:0] addr_nxt;
    assign addr_nxt = addr_q + 1'b1;
`endif

    assign cfg_word = {{(DATA_W-2){1'b0}}, cfg_lat};
    assign wait_out = (st_q == RD_LAT);
    assign state    = st_q;

    // Drive drops the instant the controller turns the bus around (we low).
    assign drv_en = (st_q == RD_DRV) && !ce && !oe && we;
    assign sram_data[HALF-1:0]      = (drv_en && !lb) ? rd_q[HALF-1:0]      : 'z;
    assign sram_data[DATA_W-1:HALF] = (drv_en && !ub) ? rd_q[DATA_W-1:HALF] : 'z;

    always_comb begin
        st_d      = st_q;
        latch     = 1'b0;
        do_wr     = 1'b0;
        ld_rd     = 1'b0;
        lat_start = 1'b0;
        lat_inc   = 1'b0;
`ifdef SRAM_RESP_BURST_EN
        rd_step   = 1'b0;
`endif
        case (st_q)
            IDLE: begin
                if (!ce && !adv) begin
                    latch = 1'b1;
                    st_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ce)        st_d = IDLE;
                else if (!adv) latch = 1'b1;
                else if (!we)  do_wr = 1'b1;
                else if (!oe) begin
                    ld_rd = 1'b1;
                    if (cfg_lat == 2'd0) st_d = RD_DRV;
                    else begin
                        lat_start = 1'b1;
                        st_d      = RD_LAT;
                    end
                end
            end
            RD_LAT: begin
                if (ce)                     st_d = IDLE;
                else if (oe)                st_d = ACTIVE;
                else if (lat_cnt == cfg_lat) st_d = RD_DRV;
                else                        lat_inc = 1'b1;
            end
            RD_DRV: begin
                if (ce)       st_d = IDLE;
                else if (oe)  st_d = ACTIVE;
                else if (!we) begin
                    do_wr = 1'b1;
                    st_d  = ACTIVE;
                end
`ifdef SRAM_RESP_BURST_EN
                else          rd_step = !is_cfg;
`endif
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= IDLE;
            addr_q    <= '0;
            is_cfg    <= 1'b0;
            cfg_lat   <= 2'(READ_LAT);
            lat_cnt   <= 2'd0;
            rd_q      <= '0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            st_q      <= st_d;
            wr_strobe <= do_wr;
            rd_strobe <= (st_d == RD_DRV) && (st_q != RD_DRV);
            if (latch) begin
                addr_q <= sram_addr;
                is_cfg <= cre;
            end
            if (do_wr) begin
                if (is_cfg) cfg_lat <= sram_data[1:0];
                else begin
                    if (!lb) mem[addr_q][HALF-1:0]      <= sram_data[HALF-1:0];
                    if (!ub) mem[addr_q][DATA_W-1:HALF] <= sram_data[DATA_W-1:HALF];
`ifdef SRAM_RESP_BURST_EN
                    addr_q <= addr_nxt;
`endif
                end
            end
            if (ld_rd) rd_q <= is_cfg ? cfg_word : mem[addr_q];
            if (lat_start)    lat_cnt <= 2'd1;
            else if (lat_inc) lat_cnt <= lat_cnt + 2'd1;
`ifdef SRAM_RESP_BURST_EN
            // Streaming read: next word is fetched on every held-oe edge.
            if (rd_step) begin
                addr_q    <= addr_nxt;
                rd_q      <= mem[addr_nxt];
                rd_strobe <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against an array/latency reference model.
// Undriven bus bits are pulled up, so a released lane reads as all ones.
module tb_sram_responder;
    localparam int DW = 4, AW = 4, DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] addr;
    wire  [DW-1:0] sram_data;
    logic ce, we, oe, adv, cre, lb, ub;
    logic wait_out, wr_strobe, rd_strobe;
    logic [1:0] state;
    logic tb_en;
    logic [DW-1:0] tb_wd;

    assign sram_data = tb_en ? tb_wd : 'z;
    for (genvar i = 0; i < DW; i++) begin : g_pu
        pullup (sram_data[i]);
    end

    sram_responder #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) dut (
        .clk(clk), .rst(rst), .sram_addr(addr), .sram_data(sram_data),
        .ce(ce), .we(we), .oe(oe), .adv(adv), .cre(cre), .lb(lb), .ub(ub),
        .wait_out(wait_out), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .state(state)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mdl [DEPTH];
    int mlat;

    function automatic logic [DW-1:0] bus_exp(logic [DW-1:0] v, logic l, logic u);
        return {u ? 2'b11 : v[3:2], l ? 2'b11 : v[1:0]};
    endfunction

    task automatic idle_in();
        ce = 1; adv = 1; we = 1; oe = 1; cre = 0; lb = 0; ub = 0; tb_en = 0; tb_wd = '0; addr = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mlat = 2;
    endtask

    task automatic model_write(input int a, input logic [DW-1:0] d, input logic l, input logic u, input logic c);
        if (c) mlat = int'(d[1:0]);
        else begin
            if (!l) mdl[a][1:0] = d[1:0];
            if (!u) mdl[a][3:2] = d[3:2];
        end
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic l, input logic u, input logic c);
        @(negedge clk); ce = 0; adv = 0; addr = AW'(a); cre = c;
        @(negedge clk); adv = 1; cre = 0; we = 0; lb = l; ub = u; tb_wd = d; tb_en = 1;
        @(negedge clk);
        checks++;
        if (wr_strobe !== 1'b1) begin errors++; $display("FAIL wr_strobe a=%0d got %b exp 1", a, wr_strobe); end
        model_write(a, d, l, u, c);
        we = 1; tb_en = 0; ce = 1; lb = 0; ub = 0;
        @(negedge clk);
        checks++;
        if (wr_strobe !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL wr_end a=%0d got strobe=%b state=%0d exp 0/0", a, wr_strobe, state);
        end
    endtask

    task automatic do_read(input int a, input logic c, input logic l, input logic u);
        logic [DW-1:0] exp;
        int lat;
        exp = c ? DW'(mlat) : mdl[a];
        lat = mlat;
        @(negedge clk); ce = 0; adv = 0; addr = AW'(a); cre = c;
        @(negedge clk); adv = 1; cre = 0; oe = 0; lb = l; ub = u;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            checks++;
            if (wait_out !== 1'b1 || sram_data !== 4'hF) begin
                errors++; $display("FAIL rd_wait a=%0d cyc=%0d got wait=%b bus=%h exp 1/f", a, i, wait_out, sram_data);
            end
        end
        @(negedge clk);
        checks++;
        if (wait_out !== 1'b0 || rd_strobe !== 1'b1 || sram_data !== bus_exp(exp, l, u)) begin
            errors++;
            $display("FAIL rd_data a=%0d cfg=%b got wait=%b strobe=%b bus=%h exp 0/1/%h",
                     a, c, wait_out, rd_strobe, sram_data, bus_exp(exp, l, u));
        end
`ifndef SRAM_RESP_BURST_EN
        @(negedge clk);
        checks++;
        if (rd_strobe !== 1'b0 || sram_data !== bus_exp(exp, l, u)) begin
            errors++; $display("FAIL rd_hold a=%0d got strobe=%b bus=%h exp 0/%h", a, rd_strobe, sram_data, bus_exp(exp, l, u));
        end
`endif
        oe = 1; ce = 1; lb = 0; ub = 0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || sram_data !== 4'hF) begin
            errors++; $display("FAIL rd_end a=%0d got state=%0d bus=%h exp 0/f", a, state, sram_data);
        end
    endtask

    // Leaves the DUT at the first negedge in RD_DRV reading address a.
    task automatic go_drv(input int a);
        @(negedge clk); ce = 0; adv = 0; addr = AW'(a); cre = 0;
        @(negedge clk); adv = 1; oe = 0;
        repeat (mlat) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (state !== 2'd0 || wait_out !== 0 || wr_strobe !== 0 || rd_strobe !== 0 || sram_data !== 4'hF) begin
            errors++; $display("FAIL reset_state got state=%0d wait=%b wr=%b rd=%b bus=%h exp 0/0/0/0/f",
                               state, wait_out, wr_strobe, rd_strobe, sram_data);
        end
        @(negedge clk); rst = 1;
        model_reset();
        do_write(1, 4'h5, 0, 0, 0);
        go_drv(1);
        checks++;
        if (sram_data !== 4'h5) begin errors++; $display("FAIL pre_rst_drive got %h exp 5", sram_data); end
        #2 rst = 0;
        #1;
        checks++;
        if (sram_data !== 4'hF || state !== 2'd0 || wait_out !== 1'b0) begin
            errors++; $display("FAIL mid_rst got bus=%h state=%0d wait=%b exp f/0/0", sram_data, state, wait_out);
        end
        @(negedge clk); idle_in(); rst = 1;
        model_reset();
        do_read(1, 0, 0, 0);
    endtask

    task automatic test_write_read();
        for (int a = 1; a <= 4; a++) do_write(a, DW'(a), 0, 0, 0);
        for (int a = 1; a <= 4; a++) do_read(a, 0, 0, 0);
    endtask

    task automatic test_lane();
        do_write(3, 4'hF, 0, 1, 0);
        do_read(3, 0, 0, 0);
        do_read(3, 0, 1, 0);
        do_write(5, 4'hA, 1, 0, 0);
        do_read(5, 0, 0, 1);
        do_read(5, 0, 0, 0);
    endtask

    task automatic test_config();
        do_write(0, 4'h0, 0, 0, 1);
        do_read(2, 0, 0, 0);
        do_read(0, 1, 0, 0);
        do_write(0, 4'h2, 1, 1, 1);
        do_read(0, 1, 0, 0);
        do_read(4, 0, 0, 0);
    endtask

    task automatic test_abort();
        @(negedge clk); ce = 0; adv = 0; addr = 4'd2;
        @(negedge clk); adv = 1; oe = 0;
        @(negedge clk);
        checks++;
        if (state !== 2'd2 || wait_out !== 1'b1 || sram_data !== 4'hF) begin
            errors++; $display("FAIL abort_lat got state=%0d wait=%b bus=%h exp 2/1/f", state, wait_out, sram_data);
        end
        oe = 1;
        @(negedge clk);
        checks++;
        if (state !== 2'd1 || wait_out !== 1'b0 || sram_data !== 4'hF) begin
            errors++; $display("FAIL abort_oe got state=%0d wait=%b bus=%h exp 1/0/f", state, wait_out, sram_data);
        end
        ce = 1;
        @(negedge clk);
        go_drv(4);
        ce = 1;
        #1;
        checks++;
        if (sram_data !== 4'hF) begin errors++; $display("FAIL abort_ce_bus got %h exp f", sram_data); end
        @(negedge clk);
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL abort_ce_state got %0d exp 0", state); end
        oe = 1;
        go_drv(1);
        checks++;
        if (sram_data !== mdl[1]) begin errors++; $display("FAIL abort_we_pre got %h exp %h", sram_data, mdl[1]); end
        we = 0;
        #1;
        checks++;
        if (sram_data !== 4'hF) begin errors++; $display("FAIL abort_we_bus got %h exp f", sram_data); end
        tb_wd = 4'h6; tb_en = 1;
        @(negedge clk);
        checks++;
        if (state !== 2'd1 || wr_strobe !== 1'b1) begin
            errors++; $display("FAIL abort_we_commit got state=%0d wr=%b exp 1/1", state, wr_strobe);
        end
        model_write(1, 4'h6, 0, 0, 0);
        idle_in();
        @(negedge clk);
        do_read(1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int op, a;
            logic [DW-1:0] d;
            logic l, u;
            op = int'($urandom_range(0, 4));
            a  = int'($urandom_range(0, DEPTH - 1));
            d  = DW'($urandom);
            l  = 1'($urandom);
            u  = 1'($urandom);
            if (op <= 1)      do_write(a, d, l, u, 0);
            else if (op <= 3) do_read(a, 0, l, u);
            else begin
                do_write(a, d, l, u, 1);
                do_read(a, 1, 0, 0);
            end
        end
    endtask

`ifdef SRAM_RESP_BURST_EN
    task automatic test_burst();
        logic [DW-1:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = DW'($urandom);
        @(negedge clk); ce = 0; adv = 0; addr = 4'd14;
        @(negedge clk); adv = 1; we = 0; tb_en = 1;
        for (int i = 0; i < 3; i++) begin
            tb_wd = d[i];
            @(negedge clk);
            checks++;
            if (wr_strobe !== 1'b1) begin errors++; $display("FAIL burst_wr%0d got %b exp 1", i, wr_strobe); end
            model_write((14 + i) % DEPTH, d[i], 0, 0, 0);
        end
        we = 1; tb_en = 0; ce = 1;
        @(negedge clk);
        go_drv(15);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sram_data !== mdl[(15 + k) % DEPTH] || rd_strobe !== 1'b1) begin
                errors++; $display("FAIL burst_rd%0d got bus=%h strobe=%b exp %h/1",
                                   k, sram_data, rd_strobe, mdl[(15 + k) % DEPTH]);
            end
            if (k < 3) @(negedge clk);
        end
        oe = 1; ce = 1;
        @(negedge clk);
        do_read(14, 0, 0, 0);
        do_read(0, 0, 0, 0);
    endtask
`endif

    initial begin
        idle_in();
        model_reset();
        test_reset();
        test_write_read();
        test_lane();
        test_config();
        test_abort();
`ifdef SRAM_RESP_BURST_EN
        test_burst();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
